bus_ctl: RTL
============

# bus_ctl

Bus controller sitting directly downstream of the 65C02 `cpu` core. It consumes the core's combinatorial address bus, write data and write enable, and produces the core's `DI` and `RDY`. Accesses go either to a synchronous single-cycle RAM with no stall, or to a slow I/O page through a req/ack handshake that stalls the core via `RDY`. A timeout aborts hung I/O accesses and records a sticky error.

## Interface

Parameters:
- `IO_PAGE`, default 8'hFE: high address byte that selects the I/O region (`AD[15:8] == IO_PAGE`). All other addresses are RAM.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before an I/O access is aborted. Legal range is 1..255.

Ports:
- `clk` input, 1: CPU clock. Single clock domain.
- `RST` input, 1: reset. Synchronous, active-high.
- `AD` input, 16: CPU address bus (combinatorial from core).
- `DO` input, 8: CPU write data.
- `WE` input, 1: CPU write enable.
- `DI` output, 8: read data to the CPU.
- `RDY` output, 1: CPU ready. 0 stalls the core.
- `ram_addr` output, 16: RAM address. Equals `AD`.
- `ram_we` output, 1: RAM write strobe.
- `ram_wdata` output, 8: RAM write data. Equals `DO`.
- `ram_rdata` input, 8: RAM read data. Registered RAM, valid the cycle after the address.
- `io_req` output, 1: I/O request.
- `io_we` output, 1: I/O write (1) or read (0). Valid while `io_req`.
- `io_addr` output, 8: I/O register offset (`AD[7:0]` latched).
- `io_wdata` output, 8: I/O write data (latched `DO`).
- `io_rdata` input, 8: I/O read data. Sampled in the cycle `io_ack` is seen.
- `io_ack` input, 1: I/O completion. Single-cycle pulse; ignored when `io_req` is 0.
- `bus_err` output, 1: sticky timeout flag.
- `err_addr` output, 16: full address of the first timed-out access.

## Operation

- States: IDLE, WAIT, DONE.
- `RDY` is a function of state only: 1 in IDLE and DONE, 0 in WAIT. It never depends combinatorially on `AD`.
- An access is **taken** in any cycle with `RDY = 1`. `AD`, `WE` and `DO` are ignored while `RDY = 0`.

IDLE / DONE, access taken:
- RAM region: `ram_we = WE`. Remain or return to IDLE. Set `src = RAM`.
- I/O region: latch `io_addr <= AD[7:0]`, `io_we <= WE`, `io_wdata <= DO`, and `err_addr` candidate `<= AD`. Clear the wait counter. Go to WAIT. `ram_we = 0`.

WAIT:
- `io_req = 1` and `ram_we = 0`.
- If `io_ack`: latch `io_dat <= io_rdata` (don't-care for writes) and go to DONE.
- Else if the counter has reached `TIMEOUT - 1`: `io_dat <= 8'hFF`. Set `bus_err` if it is clear, and capture `err_addr` only on the 0->1 transition. Go to DONE.
- Else increment the counter.
- `io_ack` in the final timeout cycle takes priority over the timeout.

DI mux:
- `DI = ram_rdata` in the cycle after a taken RAM access.
- `DI = io_dat` while in DONE.
- `DI` is held at its last value during WAIT.

Other rules:
- `ram_addr` and `ram_wdata` are always pass-through. A RAM read side effect during WAIT is harmless.
- `bus_err` and `err_addr` are cleared only by `RST`.

## Timing

- Reset values: state IDLE, `RDY = 1`, `io_req = 0`, `io_we = 0`, `io_addr = 0`, `io_wdata = 0`, `bus_err = 0`, `err_addr = 0`, `DI = 0`, counter 0, `src = RAM`.
- RAM access: address in cycle N, data on `DI` in cycle N+1, zero stall. Back-to-back accesses are supported every cycle.
- I/O access taken in cycle N:
  - `io_req` is high from N+1.
  - `io_ack` seen in cycle K (K >= N+1) gives DONE in K+1 with `RDY = 1` and `DI` valid.
  - `io_req` is low in K+1.
  - Minimum stall is 1 cycle (ack in N+1).
- Timeout: with no ack, WAIT spans N+1..N+TIMEOUT, and DONE with `DI = FF` and `bus_err = 1` occurs in N+TIMEOUT+1.
- An I/O access may be taken in DONE. This gives a back-to-back I/O sequence DONE -> WAIT, and `io_req` drops for exactly one cycle between requests.
- `RST` asserted in WAIT: IDLE next cycle and `io_req = 0` next cycle. An ack arriving in the reset cycle is discarded.
- Counter width is `$clog2(TIMEOUT+1)`. It must not wrap.

## Test plan

- RAM read then write: `AD = 0x0200` read with `ram_rdata = 0x5A`. Required: `DI = 0x5A` next cycle and `RDY` stays 1. Then `AD = 0x0201`, `WE = 1`, `DO = 0x33`. Required: `ram_we = 1` that cycle only.
- I/O read, ack after 3 cycles: `AD = 0xFE10`, `io_rdata = 0xC4`. Required: `io_req` high for 3 cycles, `io_addr = 0x10`, `io_we = 0`, `RDY` low for 3 cycles, then `RDY = 1` and `DI = 0xC4`.
- I/O write, immediate ack: `AD = 0xFE05`, `WE = 1`, `DO = 0x7E`. Required: `io_we = 1`, `io_wdata = 0x7E`, exactly one stall cycle, and `ram_we` never asserted.
- Timeout with `TIMEOUT = 15`, no ack on `AD = 0xFE20`. Required: `RDY` low for 15 cycles, then `DI = 0xFF`, `bus_err = 1`, `err_addr = 0xFE20`. A second timeout at `0xFE21` leaves `err_addr = 0xFE20`.
- Ack coincident with the last timeout cycle: required `DI = io_rdata` and `bus_err` remains 0.
- Reset mid-WAIT: `RST` asserted in the 2nd WAIT cycle. Required: next cycle `io_req = 0`, `RDY = 1`, `bus_err = 0`, and a following RAM access proceeds normally.

Source files
------------

// File: rtl/bus_ctl.sv
// bus_ctl: 65C02 bus controller. Routes CPU accesses either to a zero-wait
// registered RAM or to a slow I/O page via a req/ack handshake that stalls
// the core through RDY. Hung I/O accesses are aborted after TIMEOUT wait
// cycles, returning 8'hFF and raising a sticky error with the faulting address.
module bus_ctl #(
  parameter logic [7:0] IO_PAGE = 8'hFE,
  parameter int         TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        bus_err,
  output logic [15:0] err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          ram_vld_reg;   // previous cycle took a RAM access (src = RAM)
  logic [7:0]    io_dat_reg;    // data returned by the last I/O access
  logic [7:0]    di_hold_reg;   // last value presented on DI, held through WAIT
  logic [15:0]   cand_reg;      // full address of the I/O access in flight
  logic          io_sel;

  // RDY and io_req depend only on the registered state, never on AD.
  assign RDY    = (state_reg != S_WAIT);
  assign io_req = (state_reg == S_WAIT);
  assign io_sel = (AD[15:8] == IO_PAGE);

  // RAM side is pass-through; the write strobe only fires on a taken RAM access.
  assign ram_addr  = AD;
  assign ram_wdata = DO;
  assign ram_we    = RDY & ~io_sel & WE;

  // Read-data mux: I/O result in DONE, RAM data after a RAM access, else hold.
  always_comb begin
    DI = di_hold_reg;
    if (state_reg == S_DONE)
      DI = io_dat_reg;
    else if (ram_vld_reg)
      DI = ram_rdata;
  end

  // Remember what DI showed so it stays stable while the core is stalled.
  always_ff @(posedge clk) begin
    if (RST)
      di_hold_reg <= 8'h00;
    else
      di_hold_reg <= DI;
  end

  // Access sequencer: takes accesses when ready, runs the I/O handshake and timeout.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      ram_vld_reg <= 1'b0;
      io_dat_reg  <= 8'h00;
      cand_reg    <= 16'h0000;
      io_we       <= 1'b0;
      io_addr     <= 8'h00;
      io_wdata    <= 8'h00;
      bus_err     <= 1'b0;
      err_addr    <= 16'h0000;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (io_sel) begin
            io_addr     <= AD[7:0];
            io_we       <= WE;
            io_wdata    <= DO;
            cand_reg    <= AD;
            cnt_reg     <= '0;
            ram_vld_reg <= 1'b0;
            state_reg   <= S_WAIT;
          end else begin
            ram_vld_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        S_WAIT: begin
          ram_vld_reg <= 1'b0;
          if (io_ack) begin
            // An ack in the final cycle wins over the timeout.
            io_dat_reg <= io_rdata;
            state_reg  <= S_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            io_dat_reg <= 8'hFF;
            if (!bus_err) begin
              bus_err  <= 1'b1;
              err_addr <= cand_reg;
            end
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
